// File: rtl/fib_scheduler_pkg.sv
// Shared definitions for the fib core scheduler: FSM state encodings,
// default widths/limits and a small helper for sizing the run counter.
package fib_scheduler_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1000;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_LOAD = 2'd1;
    localparam logic [1:0] ENC_RUN  = 2'd2;
    localparam logic [1:0] ENC_RESP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_LOAD = ENC_LOAD,
        ST_RUN  = ENC_RUN,
        ST_RESP = ENC_RESP
    } state_t;

    // Counter width able to hold TIMEOUT_CYCLES-1, never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fib_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping around, and reports it one-hot and as a binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             found;
    int               cand;
    logic [SEL_W-1:0] sel;

    // Cyclic scan starting at ptr; the first hit wins and masks the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        sel   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            sel  = SEL_W'(cand);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                idx        = IDX_W'(cand);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_scheduler.sv
// Shares one fib core between NUM_REQ requesters: round-robin accept, load n
// into the core, wait for its write strobe (or time out) and return the
// result tagged with the requester id. One request is in flight at a time.
module fib_scheduler
    import fib_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_n,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_timeout,
    output logic                      core_rst,
    output logic [DATA_W-1:0]         core_data,
    input  logic                      core_wen,
    input  logic [DATA_W-1:0]         core_result
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;
    logic [DATA_W-1:0]   win_n;
    logic [ID_W-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Winner's operand and the pointer slot just past the winner.
    always_comb begin
        win_n    = '0;
        next_ptr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_n    = req_n[i*DATA_W +: DATA_W];
                next_ptr = ID_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Grants are only offered while idle; the handshake completes on this edge.
    assign req_ready = (state == ST_IDLE) ? arb_grant : '0;

    // Scheduler FSM with registered core control and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            core_rst    <= 1'b1;
            core_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    core_rst <= 1'b1;
                    if (|req_valid) begin
                        core_data <= win_n;
                        rsp_id    <= arb_idx;
                        rr_ptr    <= next_ptr;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt      <= '0;
                    core_rst <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    // A strobe in the last allowed cycle still counts as a result.
                    if (core_wen) begin
                        rsp_data    <= core_result;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        core_rst    <= 1'b1;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        core_rst    <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_scheduler.sv
// Directed bench for fib_scheduler with a behavioural fib core and a stub
// core path for exercising the run timeout.
module tb_fib_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [31:0]  req_n_arr [4];
    logic [127:0] req_n;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_timeout;
    logic         core_rst;
    logic [31:0]  core_data;
    logic         core_wen;
    logic [31:0]  core_result;

    logic [31:0]  ca, cb, ccnt;
    logic         cdone;
    logic         model_wen;
    logic         stub_mode, stub_wen;
    logic [31:0]  stub_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign req_n = {req_n_arr[3], req_n_arr[2], req_n_arr[1], req_n_arr[0]};

    fib_scheduler #(
        .NUM_REQ        (4),
        .ID_W           (2),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_n       (req_n),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .core_rst    (core_rst),
        .core_data   (core_data),
        .core_wen    (core_wen),
        .core_result (core_result)
    );

    // Behavioural fib core: iterates while out of reset, strobes fib(n) once.
    always @(posedge clk) begin
        if (core_rst) begin
            ca    <= 32'd0;
            cb    <= 32'd1;
            ccnt  <= 32'd0;
            cdone <= 1'b0;
        end else if (!cdone) begin
            if (ccnt == core_data) begin
                cdone <= 1'b1;
            end else begin
                ca   <= cb;
                cb   <= ca + cb;
                ccnt <= ccnt + 32'd1;
            end
        end
    end

    assign model_wen   = !core_rst && !cdone && (ccnt == core_data);
    assign core_wen    = stub_mode ? stub_wen : model_wen;
    assign core_result = stub_mode ? stub_result : ca;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic raise(input logic [1:0] id, input logic [31:0] n);
        req_n_arr[id] = n;
        req_valid[id] = 1'b1;
    endtask

    // Poll for a grant, let the accept edge pass, then withdraw that request.
    task automatic wait_grant(output logic [1:0] gid);
        bit ok;
        ok  = 1'b0;
        gid = 2'd0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != 4'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("grant_bound", 64'(0), 64'(1));
        end else begin
            for (int i = 0; i < 4; i++)
                if (req_ready[i]) gid = 2'(i);
            @(posedge clk);
            #1;
            req_valid[gid] = 1'b0;
        end
    endtask

    // Count cycles after the accept until rsp_valid; optionally pulse the stub strobe.
    task automatic wait_rsp(input int wen_at, output int m);
        m = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            stub_wen = (c == wen_at);
            if (rsp_valid) begin
                m = c;
                break;
            end
        end
        stub_wen = 1'b0;
        if (m == 0) check("rsp_bound", 64'(0), 64'(1));
    endtask

    task automatic serve_one(input int wen_at, output logic [1:0] gid, output int m);
        wait_grant(gid);
        wait_rsp(wen_at, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        int         m;
        int         seen;
        logic [1:0] exp_id3 [4];
        logic [31:0] exp_d3 [4];

        exp_id3 = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_d3  = '{32'd1, 32'd2, 32'd3, 32'd5};

        rst         = 1'b1;
        req_valid   = 4'd0;
        rsp_ready   = 1'b1;
        stub_mode   = 1'b0;
        stub_wen    = 1'b0;
        stub_result = 32'h0000ABCD;
        for (int i = 0; i < 4; i++) req_n_arr[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        check("rst_core_rst", 64'(core_rst), 64'(1));
        check("rst_core_data", 64'(core_data), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));

        // 1: single request, n=6 -> 8, latency 3+k with k=6
        @(negedge clk);
        raise(2'd0, 32'd6);
        serve_one(0, g, m);
        check("t1_grant", 64'(g), 64'(0));
        check("t1_latency", 64'(m), 64'(9));
        check("t1_id", 64'(rsp_id), 64'(0));
        check("t1_data", 64'(rsp_data), 64'(8));
        check("t1_timeout", 64'(rsp_timeout), 64'(0));
        #1 check("t1_no_ready_in_resp", 64'(req_ready), 64'(0));

        // 2: n=0 then n=1 from req1
        @(negedge clk);
        raise(2'd1, 32'd0);
        serve_one(0, g, m);
        check("t2a_latency", 64'(m), 64'(3));
        check("t2a_id", 64'(rsp_id), 64'(1));
        check("t2a_data", 64'(rsp_data), 64'(0));
        raise(2'd1, 32'd1);
        serve_one(0, g, m);
        check("t2b_latency", 64'(m), 64'(4));
        check("t2b_id", 64'(rsp_id), 64'(1));
        check("t2b_data", 64'(rsp_data), 64'(1));

        // 3: reset to rr_ptr=0, then all four at once
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        raise(2'd0, 32'd2);
        raise(2'd1, 32'd3);
        raise(2'd2, 32'd4);
        raise(2'd3, 32'd5);
        for (int r = 0; r < 4; r++) begin
            serve_one(0, g, m);
            check("t3_id", 64'(rsp_id), 64'(exp_id3[r]));
            check("t3_data", 64'(rsp_data), 64'(exp_d3[r]));
        end
        raise(2'd0, 32'd1);
        raise(2'd3, 32'd6);
        serve_one(0, g, m);
        check("t3_wrap_id0", 64'(rsp_id), 64'(0));
        check("t3_wrap_d0", 64'(rsp_data), 64'(1));
        serve_one(0, g, m);
        check("t3_wrap_id3", 64'(rsp_id), 64'(3));
        check("t3_wrap_d3", 64'(rsp_data), 64'(8));

        // 4: backpressure with a pending req2
        @(negedge clk);
        rsp_ready = 1'b0;
        raise(2'd0, 32'd5);
        wait_grant(g);
        raise(2'd2, 32'd3);
        wait_rsp(0, m);
        check("t4_latency", 64'(m), 64'(8));
        for (int c = 0; c < 7; c++) begin
            #1;
            check("t4_hold_valid", 64'(rsp_valid), 64'(1));
            check("t4_hold_data", 64'(rsp_data), 64'(5));
            check("t4_hold_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        check("t4_valid_8th", 64'(rsp_valid), 64'(1));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("t4_valid_drop", 64'(rsp_valid), 64'(0));
        check("t4_req2_grant", 64'(req_ready), 64'(4'b0100));
        serve_one(0, g, m);
        check("t4_req2_id", 64'(rsp_id), 64'(2));
        check("t4_req2_data", 64'(rsp_data), 64'(2));

        // 5: timeout via stub core, then a strobe in the final run cycle
        @(posedge clk);
        #1 stub_mode = 1'b1;
        @(negedge clk);
        raise(2'd0, 32'd9);
        serve_one(0, g, m);
        check("t5_to_latency", 64'(m), 64'(18));
        check("t5_to_flag", 64'(rsp_timeout), 64'(1));
        check("t5_to_data", 64'(rsp_data), 64'(0));
        raise(2'd0, 32'd9);
        serve_one(17, g, m);
        check("t5_last_latency", 64'(m), 64'(18));
        check("t5_last_flag", 64'(rsp_timeout), 64'(0));
        check("t5_last_data", 64'(rsp_data), 64'(32'h0000ABCD));
        @(posedge clk);
        #1 stub_mode = 1'b0;

        // 6: reset during RUN aborts the request
        @(negedge clk);
        raise(2'd2, 32'd6);
        wait_grant(g);
        check("t6_grant", 64'(g), 64'(2));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_core_rst", 64'(core_rst), 64'(1));
        check("t6_core_data", 64'(core_data), 64'(0));
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("t6_no_rsp", 64'(seen), 64'(0));
        raise(2'd1, 32'd4);
        raise(2'd3, 32'd2);
        serve_one(0, g, m);
        check("t6_ptr0_id", 64'(rsp_id), 64'(1));
        check("t6_ptr0_data", 64'(rsp_data), 64'(3));
        serve_one(0, g, m);
        check("t6_next_id", 64'(rsp_id), 64'(3));
        check("t6_next_data", 64'(rsp_data), 64'(1));
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
